// File: rtl/scaler_ctrl_pkg.sv
// Shared types and helpers for the clkscaler trigger sequencer.
package scaler_ctrl_pkg;

   localparam int unsigned NUM_RATES_DEF = 6;
   localparam int unsigned IDX_W_DEF     = 3;

   typedef enum logic [1:0] {
      ST_STOP,
      ST_RUN,
      ST_SETTLE
   } state_t;

   // Callers truncate to their trigger width (at most 32 rates).
   function automatic logic [31:0] onehot(input logic [31:0] idx);
      return 32'd1 << idx;
   endfunction

endpackage

// File: rtl/rise_pulse.sv
// Registers a level input once and flags its rising edge for one clk cycle.
module rise_pulse (
   input  logic clk,
   input  logic reset,
   input  logic level,
   output logic pulse
);

   logic lvl_q;
   logic lvl_q_d;

   // Both stages track the live level during reset so an input held across
   // reset release is not mistaken for a fresh rising edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         lvl_q   <= level;
         lvl_q_d <= level;
      end else begin
         lvl_q   <= level;
         lvl_q_d <= lvl_q;
      end
   end

   assign pulse = lvl_q & ~lvl_q_d;

endmodule

// File: rtl/scaler_rate_ctrl.sv
// Run/stop, rate-step and auto-sweep sequencer driving the one-hot clkscaler
// trigger, with an enforced idle gap after every rate change.
module scaler_rate_ctrl
   import scaler_ctrl_pkg::*;
#(
   parameter int unsigned NUM_RATES    = NUM_RATES_DEF,
   parameter int unsigned IDX_W        = IDX_W_DEF,
   parameter int unsigned DEFAULT_IDX  = 2,
   parameter int unsigned SETTLE_TICKS = 2,
   parameter int unsigned DWELL_TICKS  = 10,
   parameter int unsigned TICK_W       = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start_stop,
   input  logic                 step_up,
   input  logic                 step_down,
   input  logic                 sweep_en,
   input  logic                 ref_tick,
   output logic [NUM_RATES-1:0] trigger,
   output logic [IDX_W-1:0]     rate_idx,
   output logic                 running,
   output logic                 settling
);

   localparam logic [IDX_W-1:0]  MAX_IDX    = IDX_W'(NUM_RATES - 1);
   localparam logic [IDX_W-1:0]  RST_IDX    = IDX_W'(DEFAULT_IDX);
   localparam logic [TICK_W-1:0] SETTLE_END = TICK_W'(SETTLE_TICKS);
   localparam logic [TICK_W-1:0] DWELL_END  = TICK_W'(DWELL_TICKS);

   state_t              state;
   logic [TICK_W-1:0]   tick_cnt;
   logic [TICK_W-1:0]   tick_next;
   logic                ref_q;
   logic                sweep_q;
   logic                ss_ev;
   logic                up_ev;
   logic                dn_ev;
   logic                step_ok;
   logic [IDX_W-1:0]    step_idx;
   logic [IDX_W-1:0]    sweep_idx;

   rise_pulse u_ss (.clk(clk), .reset(reset), .level(start_stop), .pulse(ss_ev));
   rise_pulse u_up (.clk(clk), .reset(reset), .level(step_up),    .pulse(up_ev));
   rise_pulse u_dn (.clk(clk), .reset(reset), .level(step_down),  .pulse(dn_ev));

   always_comb begin
      step_ok  = 1'b0;
      step_idx = rate_idx;
      if (up_ev && !dn_ev && rate_idx != MAX_IDX) begin
         step_ok  = 1'b1;
         step_idx = rate_idx + IDX_W'(1);
      end else if (dn_ev && !up_ev && rate_idx != '0) begin
         step_ok  = 1'b1;
         step_idx = rate_idx - IDX_W'(1);
      end
      sweep_idx = (rate_idx == MAX_IDX) ? '0 : rate_idx + IDX_W'(1);
      tick_next = tick_cnt + TICK_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_STOP;
         rate_idx <= RST_IDX;
         trigger  <= '0;
         running  <= 1'b0;
         settling <= 1'b0;
         tick_cnt <= '0;
         ref_q    <= 1'b0;
         sweep_q  <= 1'b0;
      end else begin
         ref_q   <= ref_tick;
         sweep_q <= sweep_en;
         case (state)
            ST_STOP: begin
               if (ss_ev) begin
                  state    <= ST_SETTLE;
                  running  <= 1'b1;
                  settling <= 1'b1;
                  tick_cnt <= '0;
               end else if (step_ok) begin
                  rate_idx <= step_idx;
               end
            end
            ST_RUN: begin
               if (ss_ev) begin
                  state    <= ST_STOP;
                  trigger  <= '0;
                  running  <= 1'b0;
                  tick_cnt <= '0;
               end else if (step_ok) begin
                  state    <= ST_SETTLE;
                  rate_idx <= step_idx;
                  trigger  <= '0;
                  settling <= 1'b1;
                  tick_cnt <= '0;
               end else if (!sweep_q) begin
                  tick_cnt <= '0;
               end else if (ref_q) begin
                  if (tick_next == DWELL_END) begin
                     state    <= ST_SETTLE;
                     rate_idx <= sweep_idx;
                     trigger  <= '0;
                     settling <= 1'b1;
                     tick_cnt <= '0;
                  end else begin
                     tick_cnt <= tick_next;
                  end
               end
            end
            ST_SETTLE: begin
               if (ss_ev) begin
                  state    <= ST_STOP;
                  running  <= 1'b0;
                  settling <= 1'b0;
                  tick_cnt <= '0;
               end else if (step_ok) begin
                  // Restart the gap; a coincident ref_tick is dropped here.
                  rate_idx <= step_idx;
                  tick_cnt <= '0;
               end else if (ref_q) begin
                  if (tick_next == SETTLE_END) begin
                     state    <= ST_RUN;
                     trigger  <= NUM_RATES'(onehot(32'(rate_idx)));
                     settling <= 1'b0;
                     tick_cnt <= '0;
                  end else begin
                     tick_cnt <= tick_next;
                  end
               end
            end
            default: begin
               state    <= ST_STOP;
               trigger  <= '0;
               running  <= 1'b0;
               settling <= 1'b0;
               tick_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_scaler_rate_ctrl.sv
// Bench for scaler_rate_ctrl: directed vector table, hand sequences for the
// multi-cycle corners, and random stimulus against a per-cycle reference model.
module tb_scaler_rate_ctrl;

   localparam int NR     = 6;
   localparam int IW     = 3;
   localparam int DEF    = 2;
   localparam int SETTLE = 2;
   localparam int DWELL  = 10;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start_stop = 1'b0;
   logic          step_up = 1'b0;
   logic          step_down = 1'b0;
   logic          sweep_en = 1'b0;
   logic          ref_tick = 1'b0;
   logic [NR-1:0] trigger;
   logic [IW-1:0] rate_idx;
   logic          running;
   logic          settling;

   int errors = 0;
   int checks = 0;

   scaler_rate_ctrl #(
      .NUM_RATES(NR), .IDX_W(IW), .DEFAULT_IDX(DEF),
      .SETTLE_TICKS(SETTLE), .DWELL_TICKS(DWELL), .TICK_W(8)
   ) dut (
      .clk(clk), .reset(reset), .start_stop(start_stop), .step_up(step_up),
      .step_down(step_down), .sweep_en(sweep_en), .ref_tick(ref_tick),
      .trigger(trigger), .rate_idx(rate_idx), .running(running), .settling(settling)
   );

   always #5 clk = ~clk;

   // Reference model: mode/index/tick count plus the input levels seen at the
   // last two edges (events appear one edge after the input is first seen).
   typedef enum {M_STOP, M_RUN, M_SETTLE} mmode_t;
   mmode_t m_mode = M_STOP;
   int     m_idx = DEF;
   int     m_ticks = 0;
   bit     h1_ss, h2_ss, h1_up, h2_up, h1_dn, h2_dn, r_rt, r_sw;
   logic [NR-1:0] prev_trig = '0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   task automatic model_step();
      bit ev_ss, ev_up, ev_dn, up_ok, dn_ok;
      if (reset) begin
         m_mode = M_STOP; m_idx = DEF; m_ticks = 0;
         h1_ss = start_stop; h2_ss = start_stop;
         h1_up = step_up;    h2_up = step_up;
         h1_dn = step_down;  h2_dn = step_down;
         r_rt = 1'b0; r_sw = 1'b0;
         return;
      end
      ev_ss = h1_ss && !h2_ss;
      ev_up = h1_up && !h2_up;
      ev_dn = h1_dn && !h2_dn;
      up_ok = ev_up && !ev_dn && (m_idx < NR - 1);
      dn_ok = ev_dn && !ev_up && (m_idx > 0);
      if (ev_ss) begin
         m_mode  = (m_mode == M_STOP) ? M_SETTLE : M_STOP;
         m_ticks = 0;
      end else if (up_ok || dn_ok) begin
         if (up_ok) m_idx = m_idx + 1;
         else       m_idx = m_idx - 1;
         if (m_mode != M_STOP) begin
            m_mode  = M_SETTLE;
            m_ticks = 0;
         end
      end else if (m_mode == M_RUN) begin
         if (!r_sw) m_ticks = 0;
         else if (r_rt) begin
            m_ticks++;
            if (m_ticks == DWELL) begin
               m_idx   = (m_idx + 1) % NR;
               m_mode  = M_SETTLE;
               m_ticks = 0;
            end
         end
      end else if (m_mode == M_SETTLE && r_rt) begin
         m_ticks++;
         if (m_ticks == SETTLE) begin
            m_mode  = M_RUN;
            m_ticks = 0;
         end
      end
      h2_ss = h1_ss; h1_ss = start_stop;
      h2_up = h1_up; h1_up = step_up;
      h2_dn = h1_dn; h1_dn = step_down;
      r_rt = ref_tick; r_sw = sweep_en;
   endtask

   task automatic check_model();
      logic [31:0] exp_t;
      bit inv_ok;
      exp_t = (m_mode == M_RUN) ? (32'd1 << m_idx) : 32'd0;
      chk("model trigger",  32'(trigger),  exp_t);
      chk("model rate_idx", 32'(rate_idx), 32'(m_idx));
      chk("model running",  32'(running),  32'(m_mode != M_STOP));
      chk("model settling", 32'(settling), 32'(m_mode == M_SETTLE));
      inv_ok = (trigger == '0 || $onehot(trigger)) &&
               !(prev_trig != '0 && trigger != '0 && trigger != prev_trig);
      chk("onehot invariant", 32'(inv_ok), 32'd1);
      prev_trig = trigger;
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      check_model();
   endtask

   task automatic pulse_in(bit ss, bit up, bit dn);
      start_stop = ss; step_up = up; step_down = dn;
      cyc();
      start_stop = 1'b0; step_up = 1'b0; step_down = 1'b0;
      cyc(); cyc();
   endtask

   task automatic ticks(int n);
      for (int k = 0; k < n; k++) begin
         ref_tick = 1'b1;
         cyc();
         ref_tick = 1'b0;
         repeat (7) cyc();
      end
   endtask

   task automatic expect_out(string tag, logic [5:0] t, logic [2:0] ix, bit run, bit set);
      chk({tag, " trigger"},  32'(trigger),  32'(t));
      chk({tag, " rate_idx"}, 32'(rate_idx), 32'(ix));
      chk({tag, " running"},  32'(running),  32'(run));
      chk({tag, " settling"}, 32'(settling), 32'(set));
   endtask

   typedef struct {
      bit ss, up, dn;
      int nt;
      logic [5:0] trig;
      logic [2:0] idx;
      bit run, set;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(bit ss, bit up, bit dn, int nt,
                               logic [5:0] t, logic [2:0] ix, bit run, bit set);
      vec_t v;
      v.ss = ss; v.up = up; v.dn = dn; v.nt = nt;
      v.trig = t; v.idx = ix; v.run = run; v.set = set;
      tbl.push_back(v);
   endfunction

   initial begin
      // ss up dn ticks -> trigger idx running settling
      add(1,0,0,0, 6'b000000, 2, 1, 1);
      add(0,0,0,1, 6'b000000, 2, 1, 1);
      add(0,0,0,1, 6'b000100, 2, 1, 0);
      add(0,1,0,0, 6'b000000, 3, 1, 1);
      add(0,0,0,2, 6'b001000, 3, 1, 0);
      add(0,1,0,2, 6'b010000, 4, 1, 0);
      add(0,1,0,2, 6'b100000, 5, 1, 0);
      add(0,1,0,0, 6'b100000, 5, 1, 0);
      add(0,1,1,0, 6'b100000, 5, 1, 0);
      add(0,0,1,0, 6'b000000, 4, 1, 1);
      add(0,0,0,2, 6'b010000, 4, 1, 0);
      add(1,0,0,0, 6'b000000, 4, 0, 0);
      add(0,0,1,0, 6'b000000, 3, 0, 0);
      add(0,0,1,0, 6'b000000, 2, 0, 0);
      add(0,0,1,0, 6'b000000, 1, 0, 0);
      add(0,0,1,0, 6'b000000, 0, 0, 0);
      add(0,0,1,0, 6'b000000, 0, 0, 0);
      add(0,1,1,0, 6'b000000, 0, 0, 0);
      add(1,0,0,2, 6'b000001, 0, 1, 0);
      add(0,0,1,0, 6'b000001, 0, 1, 0);
      add(1,0,0,0, 6'b000000, 0, 0, 0);
      add(1,0,0,1, 6'b000000, 0, 1, 1);
      add(1,0,0,0, 6'b000000, 0, 0, 0);

      cyc(); cyc();
      expect_out("reset", 6'b000000, 3'd2, 1'b0, 1'b0);
      reset = 1'b0;
      cyc();

      foreach (tbl[i]) begin
         pulse_in(tbl[i].ss, tbl[i].up, tbl[i].dn);
         ticks(tbl[i].nt);
         expect_out($sformatf("vec%0d", i), tbl[i].trig, tbl[i].idx, tbl[i].run, tbl[i].set);
      end

      // Sweep from idx 4: wraps 5 -> 0 with settle gaps in between.
      repeat (4) pulse_in(0, 1, 0);
      expect_out("sweep prep", 6'b000000, 3'd4, 1'b0, 1'b0);
      sweep_en = 1'b1;
      pulse_in(1, 0, 0);
      ticks(2);  expect_out("sweep run4",    6'b010000, 3'd4, 1'b1, 1'b0);
      ticks(9);  expect_out("sweep dwell9",  6'b010000, 3'd4, 1'b1, 1'b0);
      ticks(1);  expect_out("sweep to5",     6'b000000, 3'd5, 1'b1, 1'b1);
      ticks(2);  expect_out("sweep run5",    6'b100000, 3'd5, 1'b1, 1'b0);
      ticks(10); expect_out("sweep wrap0",   6'b000000, 3'd0, 1'b1, 1'b1);
      ticks(2);  expect_out("sweep run0",    6'b000001, 3'd0, 1'b1, 1'b0);
      sweep_en = 1'b0;
      ticks(12); expect_out("sweep off",     6'b000001, 3'd0, 1'b1, 1'b0);
      pulse_in(1, 0, 0);
      expect_out("sweep stop", 6'b000000, 3'd0, 1'b0, 1'b0);

      // Step during SETTLE restarts the gap; a coincident ref_tick is dropped.
      pulse_in(1, 0, 0);
      ticks(1);
      step_up = 1'b1; ref_tick = 1'b1;
      cyc();
      step_up = 1'b0; ref_tick = 1'b0;
      repeat (7) cyc();
      expect_out("restart step", 6'b000000, 3'd1, 1'b1, 1'b1);
      ticks(1);  expect_out("restart 1tick", 6'b000000, 3'd1, 1'b1, 1'b1);
      ticks(1);  expect_out("restart run",   6'b000010, 3'd1, 1'b1, 1'b0);

      // Reset mid-SETTLE with step_up held.
      pulse_in(0, 0, 1);
      expect_out("pre reset settle", 6'b000000, 3'd0, 1'b1, 1'b1);
      step_up = 1'b1;
      cyc();
      reset = 1'b1;
      cyc();
      expect_out("mid reset", 6'b000000, 3'd2, 1'b0, 1'b0);
      reset = 1'b0;
      repeat (4) cyc();
      expect_out("held after reset", 6'b000000, 3'd2, 1'b0, 1'b0);
      step_up = 1'b0;
      cyc(); cyc();

      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 19) == 0) start_stop = ~start_stop;
         if ($urandom_range(0, 5) == 0)  step_up = ~step_up;
         if ($urandom_range(0, 5) == 0)  step_down = ~step_down;
         if ($urandom_range(0, 99) == 0) sweep_en = ~sweep_en;
         ref_tick = ((i % 8) == 0) || ($urandom_range(0, 5) == 0);
         reset = ($urandom_range(0, 599) == 0);
         cyc();
      end
      reset = 1'b0;
      cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
